// File: rtl/procyon_lsu_lq_ordered.sv
// Load queue: tracks issued loads until ROB retirement, detects store/load overlap, parks and replays loads.
// Optional macro PROCYON_LSU_LQ_AGE_ORDER_EN selects oldest-first replay; otherwise lowest-index replay.
module procyon_lsu_lq_ordered #(
  parameter int unsigned OPTN_ADDR_WIDTH    = 32,
  parameter int unsigned OPTN_LQ_DEPTH      = 8,
  parameter int unsigned OPTN_ROB_IDX_WIDTH = 5,
  parameter int unsigned OPTN_MHQ_IDX_WIDTH = 2,
  parameter int unsigned OPTN_REPLAY_PORTS  = 1,
  localparam int unsigned OPTN_OP_WIDTH     = 3
) (
  input  logic                                                   clk,
  input  logic                                                   n_rst,
  input  logic                                                   i_flush,
  input  logic                                                   i_sq_nonspeculative_pending,
  output logic                                                   o_full,
  output logic [$clog2(OPTN_LQ_DEPTH):0]                         o_occupancy,
  input  logic                                                   i_alloc_en,
  input  logic [OPTN_OP_WIDTH-1:0]                               i_alloc_op,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0]                          i_alloc_tag,
  input  logic [OPTN_ADDR_WIDTH-1:0]                             i_alloc_addr,
  output logic [OPTN_LQ_DEPTH-1:0]                               o_alloc_lq_select,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0]                          i_rob_head_tag,
  input  logic [OPTN_REPLAY_PORTS-1:0]                           i_replay_stall,
  output logic [OPTN_REPLAY_PORTS-1:0]                           o_replay_en,
  output logic [OPTN_REPLAY_PORTS-1:0][OPTN_LQ_DEPTH-1:0]        o_replay_select,
  output logic [OPTN_REPLAY_PORTS-1:0][OPTN_OP_WIDTH-1:0]        o_replay_op,
  output logic [OPTN_REPLAY_PORTS-1:0][OPTN_ROB_IDX_WIDTH-1:0]   o_replay_tag,
  output logic [OPTN_REPLAY_PORTS-1:0][OPTN_ADDR_WIDTH-1:0]      o_replay_addr,
  input  logic                                                   i_update_en,
  input  logic [OPTN_LQ_DEPTH-1:0]                               i_update_select,
  input  logic                                                   i_update_retry,
  input  logic                                                   i_update_replay,
  input  logic [OPTN_MHQ_IDX_WIDTH-1:0]                          i_update_mhq_tag,
  input  logic                                                   i_update_mhq_retry,
  input  logic                                                   i_update_mhq_replay,
  input  logic                                                   i_mhq_fill_en,
  input  logic [OPTN_MHQ_IDX_WIDTH-1:0]                          i_mhq_fill_tag,
  input  logic                                                   i_sq_retire_en,
  input  logic [OPTN_ADDR_WIDTH-1:0]                             i_sq_retire_addr,
  input  logic [OPTN_OP_WIDTH-1:0]                               i_sq_retire_op,
  input  logic                                                   i_rob_retire_en,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0]                          i_rob_retire_tag,
  output logic                                                   o_rob_retire_ack,
  output logic                                                   o_rob_retire_misspeculated
);

  localparam int unsigned DEPTH  = OPTN_LQ_DEPTH;
  localparam int unsigned RP     = OPTN_REPLAY_PORTS;
  localparam int unsigned IDX_W  = $clog2(OPTN_LQ_DEPTH);
  localparam int unsigned OCC_W  = IDX_W + 1;
  localparam int unsigned OCC_W1 = OCC_W + 1;
  localparam int unsigned AW     = OPTN_ADDR_WIDTH;
  localparam int unsigned AW1    = OPTN_ADDR_WIDTH + 1;
  localparam int unsigned ROB_W  = OPTN_ROB_IDX_WIDTH;
  localparam int unsigned MHQ_W  = OPTN_MHQ_IDX_WIDTH;
  localparam int unsigned OP_W   = OPTN_OP_WIDTH;

  localparam logic [OP_W-1:0] LSU_LB  = 3'd0;
  localparam logic [OP_W-1:0] LSU_LH  = 3'd1;
  localparam logic [OP_W-1:0] LSU_LW  = 3'd2;
  localparam logic [OP_W-1:0] LSU_LBU = 3'd3;
  localparam logic [OP_W-1:0] LSU_LHU = 3'd4;
  localparam logic [OP_W-1:0] LSU_SB  = 3'd5;
  localparam logic [OP_W-1:0] LSU_SH  = 3'd6;
  localparam logic [OP_W-1:0] LSU_SW  = 3'd7;

  typedef enum logic [2:0] {
    LQ_EMPTY,
    LQ_LAUNCHED,
    LQ_READY,
    LQ_RETRY_WAIT,
    LQ_MHQ_WAIT
  } lq_state_t;

  lq_state_t         r_state   [DEPTH];
  logic [OP_W-1:0]   r_op      [DEPTH];
  logic [ROB_W-1:0]  r_tag     [DEPTH];
  logic [AW-1:0]     r_addr    [DEPTH];
  logic [MHQ_W-1:0]  r_mhq_tag [DEPTH];
  logic [DEPTH-1:0]  r_misspec;

  logic [DEPTH-1:0]  w_empty;
  logic [DEPTH-1:0]  w_ready;
  logic [DEPTH-1:0]  w_first_empty;
  logic [DEPTH-1:0]  w_alloc_sel;
  logic [DEPTH-1:0]  w_retire_match;
  logic [DEPTH-1:0]  w_store_overlap;
  logic [DEPTH-1:0]  w_fill_match;
  logic [DEPTH-1:0]  w_update;
  logic [DEPTH-1:0]  w_replay_take;
  logic              w_alloc_overlap;
  logic              w_alloc_any;
  logic              w_retire_en;
  logic              w_retire_any;
  logic              w_retire_misspec;
  logic              w_update_fill_hit;
  logic [OCC_W1-1:0] w_occ_sum;
  logic [OCC_W-1:0]  w_occ_next;
  logic [RP-1:0][DEPTH-1:0] w_pick;
  logic [OP_W-1:0]   w_rp_op   [RP];
  logic [ROB_W-1:0]  w_rp_tag  [RP];
  logic [AW-1:0]     w_rp_addr [RP];

  function automatic logic [2:0] f_load_size(input logic [OP_W-1:0] op);
    case (op)
      LSU_LB, LSU_LBU: return 3'd1;
      LSU_LH, LSU_LHU: return 3'd2;
      default:         return 3'd4;
    endcase
  endfunction

  function automatic logic [2:0] f_store_size(input logic [OP_W-1:0] op);
    case (op)
      LSU_SB:  return 3'd1;
      LSU_SH:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Spans are compared one bit wider so an end address past the top of memory does not wrap.
  function automatic logic f_overlap(input logic [AW-1:0] la, input logic [OP_W-1:0] lop,
                                     input logic [AW-1:0] sa, input logic [OP_W-1:0] sop);
    logic [AW1-1:0] l_lo, l_hi, s_lo, s_hi;
    l_lo = AW1'(la);
    l_hi = l_lo + AW1'(f_load_size(lop));
    s_lo = AW1'(sa);
    s_hi = s_lo + AW1'(f_store_size(sop));
    return (l_lo < s_hi) && (s_lo < l_hi);
  endfunction

  // Per-entry status, allocation, retire and overlap terms.
  always_comb begin
    w_empty          = '0;
    w_ready          = '0;
    w_first_empty    = '0;
    w_retire_match   = '0;
    w_store_overlap  = '0;
    w_fill_match     = '0;
    w_update         = '0;
    w_retire_en      = i_rob_retire_en && !i_sq_nonspeculative_pending && !i_flush;
    for (int i = 0; i < DEPTH; i++) begin
      w_empty[i]         = (r_state[i] == LQ_EMPTY);
      w_ready[i]         = (r_state[i] == LQ_READY);
      w_retire_match[i]  = w_retire_en && !w_empty[i] && (r_tag[i] == i_rob_retire_tag);
      w_store_overlap[i] = i_sq_retire_en && f_overlap(r_addr[i], r_op[i], i_sq_retire_addr, i_sq_retire_op);
      w_fill_match[i]    = i_mhq_fill_en && (r_mhq_tag[i] == i_mhq_fill_tag);
      w_update[i]        = i_update_en && i_update_select[i] && (r_state[i] == LQ_LAUNCHED);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_empty[i]) w_first_empty = DEPTH'(1) << i;
    end
    w_alloc_sel       = (i_alloc_en && !i_flush) ? w_first_empty : '0;
    w_alloc_any       = |w_alloc_sel;
    w_alloc_overlap   = i_sq_retire_en && f_overlap(i_alloc_addr, i_alloc_op, i_sq_retire_addr, i_sq_retire_op);
    w_retire_any      = |w_retire_match;
    w_retire_misspec  = |(w_retire_match & (r_misspec | w_store_overlap));
    w_update_fill_hit = i_mhq_fill_en && (i_mhq_fill_tag == i_update_mhq_tag);
  end

  assign o_full = ~|(w_empty & ~w_alloc_sel);

  // Occupancy: add alloc, subtract retire with a floor at zero.
  always_comb begin
    w_occ_sum = {1'b0, o_occupancy} + OCC_W1'(w_alloc_any);
    if (w_retire_any) begin
      w_occ_sum = (w_occ_sum == '0) ? '0 : (w_occ_sum - OCC_W1'(1));
    end
    w_occ_next = i_flush ? '0 : OCC_W'(w_occ_sum);
  end

`ifdef PROCYON_LSU_LQ_AGE_ORDER_EN
  logic [ROB_W-1:0] w_age [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_age[i] = ROB_W'(r_tag[i] - i_rob_head_tag);
    end
  end
`else
  logic w_unused_head;
  assign w_unused_head = ^i_rob_head_tag;
`endif

  // Replay selection; each port excludes entries taken by higher-priority ports.
  always_comb begin : replay_pick
    logic [DEPTH-1:0] taken;
    logic             found;
    logic [IDX_W-1:0] best;
`ifdef PROCYON_LSU_LQ_AGE_ORDER_EN
    logic [ROB_W-1:0] best_age;
    best_age = '0;
`endif
    taken  = '0;
    found  = 1'b0;
    best   = '0;
    w_pick = '0;
    for (int p = 0; p < RP; p++) begin
      found = 1'b0;
      best  = '0;
`ifdef PROCYON_LSU_LQ_AGE_ORDER_EN
      best_age = '0;
`endif
      if (!i_replay_stall[p] && !i_flush) begin
        for (int i = 0; i < DEPTH; i++) begin
`ifdef PROCYON_LSU_LQ_AGE_ORDER_EN
          if (w_ready[i] && !taken[i] && (!found || (w_age[i] < best_age))) begin
            found    = 1'b1;
            best     = IDX_W'(i);
            best_age = w_age[i];
          end
`else
          if (w_ready[i] && !taken[i] && !found) begin
            found = 1'b1;
            best  = IDX_W'(i);
          end
`endif
        end
        if (found) w_pick[p][best] = 1'b1;
      end
      taken = taken | w_pick[p];
    end
    w_replay_take = taken;
  end

  always_comb begin
    for (int p = 0; p < RP; p++) begin
      w_rp_op[p]   = '0;
      w_rp_tag[p]  = '0;
      w_rp_addr[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_pick[p][i]) begin
          w_rp_op[p]   = w_rp_op[p] | r_op[i];
          w_rp_tag[p]  = w_rp_tag[p] | r_tag[i];
          w_rp_addr[p] = w_rp_addr[p] | r_addr[i];
        end
      end
    end
  end

  // Entry state machines; flush and retire free an entry ahead of everything else.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i]   <= LQ_EMPTY;
        r_op[i]      <= '0;
        r_tag[i]     <= '0;
        r_addr[i]    <= '0;
        r_mhq_tag[i] <= '0;
        r_misspec[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_flush || w_retire_match[i]) begin
          r_state[i]   <= LQ_EMPTY;
          r_misspec[i] <= 1'b0;
        end else begin
          case (r_state[i])
            LQ_EMPTY: begin
              if (w_alloc_sel[i]) begin
                r_state[i]   <= LQ_LAUNCHED;
                r_op[i]      <= i_alloc_op;
                r_tag[i]     <= i_alloc_tag;
                r_addr[i]    <= i_alloc_addr;
                r_misspec[i] <= w_alloc_overlap;
              end
            end
            LQ_LAUNCHED: begin
              if (w_update[i]) begin
                if (i_update_replay || i_update_mhq_replay) begin
                  r_state[i] <= LQ_READY;
                end else if (i_update_retry) begin
                  r_state[i] <= i_mhq_fill_en ? LQ_READY : LQ_RETRY_WAIT;
                end else if (i_update_mhq_retry) begin
                  r_state[i]   <= w_update_fill_hit ? LQ_READY : LQ_MHQ_WAIT;
                  r_mhq_tag[i] <= i_update_mhq_tag;
                end
              end
            end
            LQ_READY:      if (w_replay_take[i]) r_state[i] <= LQ_LAUNCHED;
            LQ_RETRY_WAIT: if (i_mhq_fill_en) r_state[i] <= LQ_READY;
            LQ_MHQ_WAIT:   if (w_fill_match[i]) r_state[i] <= LQ_READY;
            default:       r_state[i] <= LQ_EMPTY;
          endcase
          if (!w_empty[i] && w_store_overlap[i]) r_misspec[i] <= 1'b1;
        end
      end
    end
  end

  // Registered responses to allocation, retirement and occupancy.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_alloc_lq_select          <= '0;
      o_occupancy                <= '0;
      o_rob_retire_ack           <= 1'b0;
      o_rob_retire_misspeculated <= 1'b0;
    end else begin
      o_alloc_lq_select          <= w_alloc_sel;
      o_occupancy                <= w_occ_next;
      o_rob_retire_ack           <= w_retire_any;
      o_rob_retire_misspeculated <= w_retire_misspec;
    end
  end

  // Replay ports; a stalled port holds its last outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_replay_en     <= '0;
      o_replay_select <= '0;
      o_replay_op     <= '0;
      o_replay_tag    <= '0;
      o_replay_addr   <= '0;
    end else begin
      for (int p = 0; p < RP; p++) begin
        if (i_flush) begin
          o_replay_en[p] <= 1'b0;
        end else if (!i_replay_stall[p]) begin
          o_replay_en[p]     <= |w_pick[p];
          o_replay_select[p] <= w_pick[p];
          o_replay_op[p]     <= w_rp_op[p];
          o_replay_tag[p]    <= w_rp_tag[p];
          o_replay_addr[p]   <= w_rp_addr[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_procyon_lsu_lq_ordered.sv
// Scoreboard bench for procyon_lsu_lq_ordered: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_procyon_lsu_lq_ordered;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef struct packed {
    logic [7:0]  sel;
    logic [4:0]  tag;
    logic [31:0] addr;
    logic [2:0]  op;
  } rep_t;

  logic clk, n_rst;
  logic i_flush, i_sq_nonspeculative_pending;
  logic o_full;
  logic [3:0] o_occupancy;
  logic i_alloc_en;
  logic [2:0] i_alloc_op;
  logic [4:0] i_alloc_tag;
  logic [31:0] i_alloc_addr;
  logic [7:0] o_alloc_lq_select;
  logic [4:0] i_rob_head_tag;
  logic [0:0] i_replay_stall;
  logic [0:0] o_replay_en;
  logic [0:0][7:0] o_replay_select;
  logic [0:0][2:0] o_replay_op;
  logic [0:0][4:0] o_replay_tag;
  logic [0:0][31:0] o_replay_addr;
  logic i_update_en;
  logic [7:0] i_update_select;
  logic i_update_retry, i_update_replay;
  logic [1:0] i_update_mhq_tag;
  logic i_update_mhq_retry, i_update_mhq_replay;
  logic i_mhq_fill_en;
  logic [1:0] i_mhq_fill_tag;
  logic i_sq_retire_en;
  logic [31:0] i_sq_retire_addr;
  logic [2:0] i_sq_retire_op;
  logic i_rob_retire_en;
  logic [4:0] i_rob_retire_tag;
  logic o_rob_retire_ack, o_rob_retire_misspeculated;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] q_alloc [$];
  logic       q_ret   [$];
  rep_t       q_rep   [$];

  procyon_lsu_lq_ordered #(
    .OPTN_ADDR_WIDTH(32), .OPTN_LQ_DEPTH(8), .OPTN_ROB_IDX_WIDTH(5),
    .OPTN_MHQ_IDX_WIDTH(2), .OPTN_REPLAY_PORTS(1)
  ) dut (
    .clk(clk), .n_rst(n_rst), .i_flush(i_flush),
    .i_sq_nonspeculative_pending(i_sq_nonspeculative_pending),
    .o_full(o_full), .o_occupancy(o_occupancy),
    .i_alloc_en(i_alloc_en), .i_alloc_op(i_alloc_op), .i_alloc_tag(i_alloc_tag),
    .i_alloc_addr(i_alloc_addr), .o_alloc_lq_select(o_alloc_lq_select),
    .i_rob_head_tag(i_rob_head_tag), .i_replay_stall(i_replay_stall),
    .o_replay_en(o_replay_en), .o_replay_select(o_replay_select), .o_replay_op(o_replay_op),
    .o_replay_tag(o_replay_tag), .o_replay_addr(o_replay_addr),
    .i_update_en(i_update_en), .i_update_select(i_update_select),
    .i_update_retry(i_update_retry), .i_update_replay(i_update_replay),
    .i_update_mhq_tag(i_update_mhq_tag), .i_update_mhq_retry(i_update_mhq_retry),
    .i_update_mhq_replay(i_update_mhq_replay),
    .i_mhq_fill_en(i_mhq_fill_en), .i_mhq_fill_tag(i_mhq_fill_tag),
    .i_sq_retire_en(i_sq_retire_en), .i_sq_retire_addr(i_sq_retire_addr), .i_sq_retire_op(i_sq_retire_op),
    .i_rob_retire_en(i_rob_retire_en), .i_rob_retire_tag(i_rob_retire_tag),
    .o_rob_retire_ack(o_rob_retire_ack), .o_rob_retire_misspeculated(o_rob_retire_misspeculated)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a response.
  always @(negedge clk) begin
    if (n_rst) begin
      if (o_alloc_lq_select != '0) begin
        if (q_alloc.size() == 0) chk("alloc_sel_unexpected", o_alloc_lq_select, 0);
        else chk("alloc_sel", o_alloc_lq_select, q_alloc.pop_front());
      end
      if (o_rob_retire_ack) begin
        if (q_ret.size() == 0) chk("retire_ack_unexpected", o_rob_retire_ack, 0);
        else chk("retire_misspec", o_rob_retire_misspeculated, q_ret.pop_front());
      end
      if (o_replay_en[0]) begin
        if (q_rep.size() == 0) chk("replay_en_unexpected", o_replay_en[0], 0);
        else begin
          rep_t e;
          e = q_rep.pop_front();
          chk("replay_select", o_replay_select[0], e.sel);
          chk("replay_tag", o_replay_tag[0], e.tag);
          chk("replay_addr", o_replay_addr[0], e.addr);
          chk("replay_op", o_replay_op[0], e.op);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [4:0] tag, input logic [31:0] addr, input logic [2:0] op,
                       input logic [7:0] exp_sel);
    i_alloc_en = 1'b1; i_alloc_tag = tag; i_alloc_addr = addr; i_alloc_op = op;
    q_alloc.push_back(exp_sel);
    cyc();
    i_alloc_en = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [2:0] op);
    i_sq_retire_en = 1'b1; i_sq_retire_addr = addr; i_sq_retire_op = op;
    cyc();
    i_sq_retire_en = 1'b0;
  endtask

  task automatic retire(input logic [4:0] tag, input logic exp_ack, input logic exp_mis);
    if (exp_ack) q_ret.push_back(exp_mis);
    i_rob_retire_en = 1'b1; i_rob_retire_tag = tag;
    cyc();
    i_rob_retire_en = 1'b0;
    chk("retire_ack", o_rob_retire_ack, exp_ack);
  endtask

  task automatic update(input logic [7:0] sel, input logic retry, input logic replay,
                        input logic [1:0] mtag, input logic mretry, input logic mreplay);
    i_update_en = 1'b1; i_update_select = sel; i_update_retry = retry; i_update_replay = replay;
    i_update_mhq_tag = mtag; i_update_mhq_retry = mretry; i_update_mhq_replay = mreplay;
    cyc();
    i_update_en = 1'b0; i_update_retry = 1'b0; i_update_replay = 1'b0;
    i_update_mhq_retry = 1'b0; i_update_mhq_replay = 1'b0;
  endtask

  task automatic fill(input logic [1:0] tag);
    i_mhq_fill_en = 1'b1; i_mhq_fill_tag = tag;
    cyc();
    i_mhq_fill_en = 1'b0;
  endtask

  task automatic exp_rep(input logic [7:0] sel, input logic [4:0] tag, input logic [31:0] addr,
                         input logic [2:0] op);
    rep_t e;
    e.sel = sel; e.tag = tag; e.addr = addr; e.op = op;
    q_rep.push_back(e);
  endtask

  initial begin
    n_rst = 1'b0; i_flush = 1'b0; i_sq_nonspeculative_pending = 1'b0;
    i_alloc_en = 1'b0; i_alloc_op = '0; i_alloc_tag = '0; i_alloc_addr = '0;
    i_rob_head_tag = '0; i_replay_stall = '0;
    i_update_en = 1'b0; i_update_select = '0; i_update_retry = 1'b0; i_update_replay = 1'b0;
    i_update_mhq_tag = '0; i_update_mhq_retry = 1'b0; i_update_mhq_replay = 1'b0;
    i_mhq_fill_en = 1'b0; i_mhq_fill_tag = '0;
    i_sq_retire_en = 1'b0; i_sq_retire_addr = '0; i_sq_retire_op = '0;
    i_rob_retire_en = 1'b0; i_rob_retire_tag = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_full", o_full, 0);
    chk("reset_occ", o_occupancy, 0);
    chk("reset_replay_en", o_replay_en, 0);
    chk("reset_ack", o_rob_retire_ack, 0);
    chk("reset_misspec", o_rob_retire_misspeculated, 0);
    chk("reset_alloc_sel", o_alloc_lq_select, 0);
    n_rst = 1'b1;
    cyc();

    // Fill all 8 entries; full rises combinationally during the 8th alloc.
    for (int i = 0; i < 8; i++) begin
      i_alloc_en = 1'b1; i_alloc_tag = 5'(i); i_alloc_addr = 32'h1000 + 32'(i * 16); i_alloc_op = OP_LW;
      #1;
      chk("full_during_alloc", o_full, (i == 7) ? 1 : 0);
      q_alloc.push_back(8'(1 << i));
      cyc();
    end
    i_alloc_en = 1'b0;
    #1;
    chk("occ_full", o_occupancy, 8);
    chk("full_held", o_full, 1);
    i_alloc_en = 1'b1; i_alloc_tag = 5'd8;
    cyc();
    i_alloc_en = 1'b0;
    chk("alloc_when_full_sel", o_alloc_lq_select, 0);
    cyc();
    chk("alloc_when_full_occ", o_occupancy, 8);
    i_flush = 1'b1;
    cyc();
    i_flush = 1'b0;
    chk("flush1_occ", o_occupancy, 0);
    chk("flush1_full", o_full, 0);

    // Store/load overlap cases.
    alloc(5'd10, 32'h100, OP_LW, 8'h01); store(32'h103, OP_SB); retire(5'd10, 1, 1);
    alloc(5'd11, 32'h100, OP_LW, 8'h01); store(32'h104, OP_SB); retire(5'd11, 1, 0);
    i_sq_retire_en = 1'b1; i_sq_retire_addr = 32'h1FE; i_sq_retire_op = OP_SW;
    alloc(5'd12, 32'h200, OP_LH, 8'h01);
    i_sq_retire_en = 1'b0;
    retire(5'd12, 1, 1);
    alloc(5'd13, 32'h200, OP_LH, 8'h01); store(32'h202, OP_SB); retire(5'd13, 1, 0);
    alloc(5'd14, 32'hFFFF_FFFC, OP_LW, 8'h01); store(32'hFFFF_FFFF, OP_SB); retire(5'd14, 1, 1);
    alloc(5'd15, 32'h300, OP_LB, 8'h01); store(32'h2FF, OP_SH); retire(5'd15, 1, 1);
    alloc(5'd16, 32'h407, OP_LBU, 8'h01); store(32'h404, OP_SW); retire(5'd16, 1, 1);
    retire(5'd31, 0, 0);
    chk("occ_after_retires", o_occupancy, 0);

    // Retire blocked by pending stores, then released.
    alloc(5'd17, 32'h500, OP_LW, 8'h01);
    i_rob_retire_en = 1'b1; i_rob_retire_tag = 5'd17; i_sq_nonspeculative_pending = 1'b1;
    cyc();
    chk("retire_pending_ack", o_rob_retire_ack, 0);
    i_sq_nonspeculative_pending = 1'b0;
    q_ret.push_back(1'b0);
    cyc();
    i_rob_retire_en = 1'b0;
    chk("retire_released_ack", o_rob_retire_ack, 1);

    // MHQ park/fill behaviour.
    alloc(5'd20, 32'h600, OP_LW, 8'h01);
    alloc(5'd21, 32'h610, OP_LH, 8'h02);
    alloc(5'd22, 32'h620, OP_LBU, 8'h04);
    update(8'h04, 0, 0, 2'd1, 1, 0);
    fill(2'd2);
    cyc(); cyc();
    chk("mhq_parked", o_replay_en, 0);
    exp_rep(8'h04, 5'd22, 32'h620, OP_LBU);
    fill(2'd1);
    chk("mhq_fill_latency", o_replay_en, 0);
    cyc();
    chk("mhq_replay_en", o_replay_en, 1);
    chk("mhq_replay_sel", o_replay_select[0], 8'h04);
    cyc();
    chk("replay_drops", o_replay_en, 0);
    update(8'h02, 1, 0, 2'd0, 0, 0);
    cyc();
    chk("retry_parked", o_replay_en, 0);
    exp_rep(8'h02, 5'd21, 32'h610, OP_LH);
    fill(2'd3);
    cyc(); cyc();
    i_mhq_fill_en = 1'b1; i_mhq_fill_tag = 2'd2;
    exp_rep(8'h01, 5'd20, 32'h600, OP_LW);
    update(8'h01, 0, 0, 2'd2, 1, 0);
    i_mhq_fill_en = 1'b0;
    cyc(); cyc();
    exp_rep(8'h04, 5'd22, 32'h620, OP_LBU);
    update(8'h04, 0, 1, 2'd0, 0, 0);
    cyc(); cyc();
    exp_rep(8'h02, 5'd21, 32'h610, OP_LH);
    update(8'h02, 0, 0, 2'd0, 0, 1);
    cyc(); cyc();
    retire(5'd20, 1, 0); retire(5'd21, 1, 0); retire(5'd22, 1, 0);

    // Replay ordering between two READY entries.
    alloc(5'd31, 32'h700, OP_LW, 8'h01);
    alloc(5'd2, 32'h710, OP_LW, 8'h02);
    i_rob_head_tag = 5'd30; i_replay_stall = 1'b1;
    update(8'h01, 0, 1, 2'd0, 0, 0);
    update(8'h02, 0, 1, 2'd0, 0, 0);
    cyc();
    chk("stall_holds", o_replay_en, 0);
    exp_rep(8'h01, 5'd31, 32'h700, OP_LW);
    exp_rep(8'h02, 5'd2, 32'h710, OP_LW);
    i_replay_stall = 1'b0;
    cyc(); cyc(); cyc();
    i_rob_head_tag = 5'd1; i_replay_stall = 1'b1;
    update(8'h01, 0, 1, 2'd0, 0, 0);
    update(8'h02, 0, 1, 2'd0, 0, 0);
`ifdef PROCYON_LSU_LQ_AGE_ORDER_EN
    exp_rep(8'h02, 5'd2, 32'h710, OP_LW);
    exp_rep(8'h01, 5'd31, 32'h700, OP_LW);
`else
    exp_rep(8'h01, 5'd31, 32'h700, OP_LW);
    exp_rep(8'h02, 5'd2, 32'h710, OP_LW);
`endif
    i_replay_stall = 1'b0;
    cyc(); cyc(); cyc();

    // Flush with five live entries and a replay about to issue.
    alloc(5'd3, 32'h900, OP_LW, 8'h04);
    alloc(5'd4, 32'h910, OP_LW, 8'h08);
    alloc(5'd5, 32'h920, OP_LW, 8'h10);
    chk("occ_five", o_occupancy, 5);
    update(8'h08, 0, 1, 2'd0, 0, 0);
    i_flush = 1'b1;
    cyc();
    i_flush = 1'b0;
    chk("flush_occ", o_occupancy, 0);
    chk("flush_replay_en", o_replay_en, 0);
    chk("flush_full", o_full, 0);
    alloc(5'd6, 32'h800, OP_LW, 8'h01);
    chk("post_flush_occ", o_occupancy, 1);
    cyc(); cyc(); cyc();

    chk("alloc_queue_drained", q_alloc.size(), 0);
    chk("retire_queue_drained", q_ret.size(), 0);
    chk("replay_queue_drained", q_rep.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
